// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: opcodes, FSM states
// and the fixed register-file slots used for ALU operands.
package sys_cmd_ctrl_pkg;

  localparam logic [7:0] OPC_RF_WR   = 8'hAA;
  localparam logic [7:0] OPC_RF_RD   = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_OPA,
    S_ALU_OPB,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_B0,
    S_TX_WAIT,
    S_TX_B1,
    S_TX_DONE
  } cmd_state_e;

  // States that are waiting on the next byte of a frame.
  function automatic logic in_frame(input cmd_state_e s);
    return s inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_OPA, S_ALU_OPB, S_ALU_FUN};
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_tx_seq.sv
// Response sender: emits one or two bytes (LSB first) to the UART
// transmitter, pacing each byte on the TX_BUSY handshake.
module sys_cmd_tx_seq
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    start_i,
  input  logic                    two_i,
  input  logic [2*DATA_WIDTH-1:0] data_i,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  output logic                    done_o
);

  cmd_state_e                  state_q;
  logic [2*DATA_WIDTH-1:0]     buf_q;
  logic                        two_q;
  logic                        seen_busy_q;
  logic [DATA_WIDTH-1:0]       tx_data_q;
  logic                        tx_vld_q;
  logic                        done_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      two_q       <= 1'b0;
      seen_busy_q <= 1'b0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start_i) begin
          buf_q   <= data_i;
          two_q   <= two_i;
          state_q <= S_TX_B0;
        end
        S_TX_B0: if (!TX_BUSY) begin
          tx_data_q   <= buf_q[DATA_WIDTH-1:0];
          tx_vld_q    <= 1'b1;
          seen_busy_q <= 1'b0;
          state_q     <= two_q ? S_TX_WAIT : S_TX_DONE;
        end
        // Second byte only goes out after a full busy rise/fall cycle.
        S_TX_WAIT: begin
          if (TX_BUSY) seen_busy_q <= 1'b1;
          else if (seen_busy_q) state_q <= S_TX_B1;
        end
        S_TX_B1: if (!TX_BUSY) begin
          tx_data_q <= buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_q  <= 1'b1;
          state_q   <= S_TX_DONE;
        end
        S_TX_DONE: if (!TX_BUSY) begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign done_o    = done_q;

endmodule

// File: rtl/sys_cmd_ctrl.sv
// UART command decoder driving a register file and ALU, returning results
// over UART. Optional inter-byte frame timeout enabled by CMD_TIMEOUT_EN.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int FUN_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic                    RF_WR_EN,
  output logic                    RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]   RF_ADDR,
  output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_BUSY
);

  cmd_state_e                  state_q;
  logic                        wr_en_q;
  logic                        rd_en_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wr_data_q;
  logic                        alu_en_q;
  logic [FUN_WIDTH-1:0]        alu_fun_q;
  logic                        gate_q;
  logic                        tx_start_q;
  logic                        tx_two_q;
  logic [2*DATA_WIDTH-1:0]     tx_data_q;
  logic                        tx_done;
  logic                        tmo_hit;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmo_q <= '0;
    end else if (!in_frame(state_q) || RX_D_VLD) begin
      tmo_q <= '0;
    end else if (tmo_q != TMO_W'(TIMEOUT_CYC)) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit = in_frame(state_q) && (tmo_q == TMO_W'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wr_data_q  <= '0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      gate_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_two_q   <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      tx_start_q <= 1'b0;
      if (tmo_hit) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: if (RX_D_VLD) begin
            if (RX_P_DATA == DATA_WIDTH'(OPC_RF_WR))        state_q <= S_WR_ADDR;
            else if (RX_P_DATA == DATA_WIDTH'(OPC_RF_RD))   state_q <= S_RD_ADDR;
            else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_OP))  state_q <= S_ALU_OPA;
            else if (RX_P_DATA == DATA_WIDTH'(OPC_ALU_NOP)) state_q <= S_ALU_FUN;
          end
          S_WR_ADDR: if (RX_D_VLD) begin
            addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q <= S_WR_DATA;
          end
          S_WR_DATA: if (RX_D_VLD) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= RX_P_DATA;
            state_q   <= S_IDLE;
          end
          S_RD_ADDR: if (RX_D_VLD) begin
            addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_q <= 1'b1;
            state_q <= S_RD_WAIT;
          end
          S_RD_WAIT: if (RF_RD_VLD) begin
            tx_data_q  <= {{DATA_WIDTH{1'b0}}, RF_RD_DATA};
            tx_two_q   <= 1'b0;
            tx_start_q <= 1'b1;
            state_q    <= S_TX_B0;
          end
          S_ALU_OPA: if (RX_D_VLD) begin
            addr_q    <= ADDR_WIDTH'(OPA_ADDR);
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= S_ALU_OPB;
          end
          S_ALU_OPB: if (RX_D_VLD) begin
            addr_q    <= ADDR_WIDTH'(OPB_ADDR);
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= S_ALU_FUN;
          end
          S_ALU_FUN: if (RX_D_VLD) begin
            alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
            alu_en_q  <= 1'b1;
            gate_q    <= 1'b1;
            state_q   <= S_ALU_WAIT;
          end
          S_ALU_WAIT: if (ALU_OUT_VLD) begin
            gate_q     <= 1'b0;
            tx_data_q  <= ALU_OUT;
            tx_two_q   <= 1'b1;
            tx_start_q <= 1'b1;
            state_q    <= S_TX_B0;
          end
          // The byte-level TX states live in the sender; here S_TX_B0
          // simply holds off new frames until the response is out.
          S_TX_B0: if (tx_done) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  sys_cmd_tx_seq #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_tx_seq (
    .CLK       (CLK),
    .RST       (RST),
    .start_i   (tx_start_q),
    .two_i     (tx_two_q),
    .data_i    (tx_data_q),
    .TX_BUSY   (TX_BUSY),
    .TX_P_DATA (TX_P_DATA),
    .TX_D_VLD  (TX_D_VLD),
    .done_o    (tx_done)
  );

  assign RF_WR_EN    = wr_en_q;
  assign RF_RD_EN    = rd_en_q;
  assign RF_ADDR     = addr_q;
  assign RF_WR_DATA  = wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = gate_q;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed bench for sys_cmd_ctrl with RF/ALU/UART-TX models and a
// scoreboard of expected RF writes, reads, ALU starts and TX bytes.
module tb_sys_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic        RF_WR_EN, RF_RD_EN;
  logic [3:0]  RF_ADDR;
  logic [7:0]  RF_WR_DATA;
  logic [7:0]  RF_RD_DATA = '0;
  logic        RF_RD_VLD = 1'b0;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATE_EN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_q[$];
  logic [3:0]  rd_q[$];
  logic [3:0]  alu_q[$];
  logic [7:0]  tx_q[$];

  logic [7:0]  rf_value  = '0;
  logic [15:0] alu_value = '0;
  int          tx_cnt  = 0;
  int          alu_cnt = 0;

  always #5 CLK = ~CLK;

  sys_cmd_ctrl #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (4),
    .FUN_WIDTH   (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_P_DATA   (RX_P_DATA),
    .RX_D_VLD    (RX_D_VLD),
    .RF_WR_EN    (RF_WR_EN),
    .RF_RD_EN    (RF_RD_EN),
    .RF_ADDR     (RF_ADDR),
    .RF_WR_DATA  (RF_WR_DATA),
    .RF_RD_DATA  (RF_RD_DATA),
    .RF_RD_VLD   (RF_RD_VLD),
    .ALU_EN      (ALU_EN),
    .ALU_FUN     (ALU_FUN),
    .CLK_GATE_EN (CLK_GATE_EN),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .TX_P_DATA   (TX_P_DATA),
    .TX_D_VLD    (TX_D_VLD),
    .TX_BUSY     (TX_BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pending();
    return wr_q.size() + rd_q.size() + alu_q.size() + tx_q.size();
  endfunction

  // Register file: answers a read one cycle later with rf_value.
  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      RF_RD_VLD = 1'b0;
    end else begin
      RF_RD_VLD = 1'b0;
      if (RF_RD_EN) begin
        RF_RD_VLD  = 1'b1;
        RF_RD_DATA = rf_value;
      end
    end
  end

  // ALU: result valid three cycles after ALU_EN.
  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      ALU_OUT_VLD = 1'b0;
      alu_cnt     = 0;
    end else begin
      ALU_OUT_VLD = 1'b0;
      if (alu_cnt != 0) begin
        alu_cnt--;
        if (alu_cnt == 0) begin
          ALU_OUT_VLD = 1'b1;
          ALU_OUT     = alu_value;
          chk("gate_at_alu_result", 32'(CLK_GATE_EN), 32'd1);
        end
      end
      if (ALU_EN) alu_cnt = 3;
    end
  end

  // UART transmitter: busy for four cycles after each accepted byte.
  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      TX_BUSY = 1'b0;
      tx_cnt  = 0;
    end else if (TX_D_VLD) begin
      chk("tx_vld_while_busy", 32'(TX_BUSY), 32'd0);
      TX_BUSY = 1'b1;
      tx_cnt  = 4;
    end else if (tx_cnt != 0) begin
      tx_cnt--;
      if (tx_cnt == 0) TX_BUSY = 1'b0;
    end
  end

  // Scoreboard: every DUT event must match the head of its queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (RF_WR_EN) begin
        chk("rf_write_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) chk("rf_write", 32'({RF_ADDR, RF_WR_DATA}), 32'(wr_q.pop_front()));
      end
      if (RF_RD_EN) begin
        chk("rf_read_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) chk("rf_read_addr", 32'(RF_ADDR), 32'(rd_q.pop_front()));
      end
      if (ALU_EN) begin
        chk("alu_en_expected", 32'(alu_q.size() != 0), 32'd1);
        if (alu_q.size() != 0) chk("alu_fun", 32'(ALU_FUN), 32'(alu_q.pop_front()));
        chk("gate_at_alu_en", 32'(CLK_GATE_EN), 32'd1);
      end
      if (TX_D_VLD) begin
        chk("tx_byte_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) chk("tx_byte", 32'(TX_P_DATA), 32'(tx_q.pop_front()));
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (pending() != 0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_outstanding"}, 32'(pending()), 32'd0);
    wr_q.delete();
    rd_q.delete();
    alu_q.delete();
    tx_q.delete();
    repeat (20) @(negedge CLK);
    chk({tag, "_gate_idle"}, 32'(CLK_GATE_EN), 32'd0);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({RF_WR_EN, RF_RD_EN, RF_ADDR, RF_WR_DATA, ALU_EN, ALU_FUN,
                CLK_GATE_EN, TX_P_DATA, TX_D_VLD});
  endfunction

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_outputs", all_outputs(), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    wr_q.push_back({4'h5, 8'h77});
    send(8'hAA); send(8'h05); send(8'h77);
    drain("write");

    rf_value = 8'h21;
    rd_q.push_back(4'h2);
    tx_q.push_back(8'h21);
    send(8'hBB); send(8'h02);
    drain("read");

    alu_value = 16'h0002;
    wr_q.push_back({4'h0, 8'h05});
    wr_q.push_back({4'h1, 8'h03});
    alu_q.push_back(4'h1);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h00);
    send(8'hCC); send(8'h05); send(8'h03); send(8'h01);
    drain("alu_operands");

    alu_value = 16'hA55A;
    alu_q.push_back(4'h1);
    tx_q.push_back(8'h5A);
    tx_q.push_back(8'hA5);
    send(8'hDD); send(8'h01);
    drain("alu_no_operands");

    send(8'h5A);
    drain("unknown_opcode");

    wr_q.push_back({4'h3, 8'h9C});
    send(8'hAA); send(8'hF3); send(8'h9C);
    drain("addr_upper_bits");

    send(8'hAA); send(8'h05);
    repeat (20) @(negedge CLK);
`ifndef CMD_TIMEOUT_EN
    wr_q.push_back({4'h5, 8'h77});
`endif
    send(8'h77);
    drain("timeout");

    send(8'hCC);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1 chk("reset_mid_frame", all_outputs(), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    rf_value = 8'h3C;
    rd_q.push_back(4'h2);
    tx_q.push_back(8'h3C);
    send(8'hBB); send(8'h02);
    drain("read_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
